// File: rtl/efpga_macc_param.sv
// efpga_macc_param: parametrised multiply / multiply-add / multiply-accumulate cell.
// Optional stage I (inputs), stage M (raw product) and stage P (result) registers.
// In MODE 2 the stage-P register doubles as the accumulator. acc_clr/acc_load
// ride along with their beat so they act when that beat's product reaches P.
module efpga_macc_param #(
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 40,
    parameter int MODE      = 0,
    parameter int SIGNED    = 1,
    parameter int REG_IN    = 1,
    parameter int PIPE_MULT = 0,
    parameter int REG_OUT   = 1,
    parameter int SATURATE  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic                 in_valid_i,
    input  logic [A_WIDTH-1:0]   a_i,
    input  logic [B_WIDTH-1:0]   b_i,
    input  logic [ACC_WIDTH-1:0] c_i,
    input  logic                 acc_clr_i,
    input  logic                 acc_load_i,
    output logic [ACC_WIDTH-1:0] y_o,
    output logic                 out_valid_o,
    output logic                 ovf_o
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int S_WIDTH = ACC_WIDTH + 1;
    // The accumulator lives in stage P, so MODE 2 always has it.
    localparam bit USE_P   = (MODE == 2) || (REG_OUT != 0);

    if ((ACC_WIDTH < P_WIDTH) || (A_WIDTH < 2) || (A_WIDTH > 27) ||
        (B_WIDTH < 2) || (B_WIDTH > 27) || (MODE < 0) || (MODE > 2)) begin : g_param_check
        $error("efpga_macc_param: illegal parameter combination");
    end

    // Full-width product, extended to the adder width (never overflows).
    function automatic logic [S_WIDTH-1:0] mul_ext(input logic [A_WIDTH-1:0] a,
                                                   input logic [B_WIDTH-1:0] b);
        logic [P_WIDTH-1:0] p;
        logic [S_WIDTH-1:0] r;
        if (SIGNED != 0) begin
            p = P_WIDTH'($signed(a)) * P_WIDTH'($signed(b));
            r = S_WIDTH'($signed(p));
        end else begin
            p = P_WIDTH'(a) * P_WIDTH'(b);
            r = S_WIDTH'(p);
        end
        return r;
    endfunction

    // Extend an accumulator-width value to the adder width.
    function automatic logic [S_WIDTH-1:0] acc_ext(input logic [ACC_WIDTH-1:0] v);
        logic [S_WIDTH-1:0] r;
        if (SIGNED != 0) begin
            r = {v[ACC_WIDTH-1], v};
        end else begin
            r = {1'b0, v};
        end
        return r;
    endfunction

    // Does the exact sum fit back into ACC_WIDTH bits?
    function automatic logic ovf_of(input logic [S_WIDTH-1:0] s);
        logic r;
        if (SIGNED != 0) begin
            r = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
        end else begin
            r = s[ACC_WIDTH];
        end
        return r;
    endfunction

    // Wrap or clamp the exact sum; bit ACC_WIDTH carries the true sign.
    function automatic logic [ACC_WIDTH-1:0] fit(input logic [S_WIDTH-1:0] s, input logic ov);
        logic [ACC_WIDTH-1:0] r;
        r = s[ACC_WIDTH-1:0];
        if (ov && (SATURATE != 0)) begin
            if (SIGNED != 0) begin
                if (s[ACC_WIDTH]) begin
                    r = {1'b1, {(ACC_WIDTH-1){1'b0}}};
                end else begin
                    r = {1'b0, {(ACC_WIDTH-1){1'b1}}};
                end
            end else begin
                r = {ACC_WIDTH{1'b1}};
            end
        end
        return r;
    endfunction

    // Stage I outputs
    logic [A_WIDTH-1:0]   a_s;
    logic [B_WIDTH-1:0]   b_s;
    logic [ACC_WIDTH-1:0] c_s;
    logic                 clr_s, load_s, valid_s;

    if (REG_IN != 0) begin : g_stage_i
        logic [A_WIDTH-1:0]   a_q;
        logic [B_WIDTH-1:0]   b_q;
        logic [ACC_WIDTH-1:0] c_q;
        logic                 clr_q, load_q, valid_q;
        // Stage I: capture operands and sideband on every enabled cycle
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_q     <= {A_WIDTH{1'b0}};
                b_q     <= {B_WIDTH{1'b0}};
                c_q     <= {ACC_WIDTH{1'b0}};
                clr_q   <= 1'b0;
                load_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (ce_i) begin
                a_q     <= a_i;
                b_q     <= b_i;
                c_q     <= c_i;
                clr_q   <= acc_clr_i;
                load_q  <= acc_load_i;
                valid_q <= in_valid_i;
            end
        end
        assign a_s     = a_q;
        assign b_s     = b_q;
        assign c_s     = c_q;
        assign clr_s   = clr_q;
        assign load_s  = load_q;
        assign valid_s = valid_q;
    end else begin : g_no_stage_i
        assign a_s     = a_i;
        assign b_s     = b_i;
        assign c_s     = c_i;
        assign clr_s   = acc_clr_i;
        assign load_s  = acc_load_i;
        assign valid_s = in_valid_i;
    end

    // Stage M outputs
    logic [S_WIDTH-1:0]   prod_m_s;
    logic [ACC_WIDTH-1:0] c_m_s;
    logic                 clr_m_s, load_m_s, valid_m_s;

    if (PIPE_MULT != 0) begin : g_stage_m
        logic [S_WIDTH-1:0]   prod_q;
        logic [ACC_WIDTH-1:0] c_q;
        logic                 clr_q, load_q, valid_q;
        // Stage M: register the raw product together with its sideband
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                prod_q  <= {S_WIDTH{1'b0}};
                c_q     <= {ACC_WIDTH{1'b0}};
                clr_q   <= 1'b0;
                load_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (ce_i) begin
                prod_q  <= mul_ext(a_s, b_s);
                c_q     <= c_s;
                clr_q   <= clr_s;
                load_q  <= load_s;
                valid_q <= valid_s;
            end
        end
        assign prod_m_s  = prod_q;
        assign c_m_s     = c_q;
        assign clr_m_s   = clr_q;
        assign load_m_s  = load_q;
        assign valid_m_s = valid_q;
    end else begin : g_no_stage_m
        assign prod_m_s  = mul_ext(a_s, b_s);
        assign c_m_s     = c_s;
        assign clr_m_s   = clr_s;
        assign load_m_s  = load_s;
        assign valid_m_s = valid_s;
    end

    // Stage P state and next-state
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ovf_q, ovf_d;
    logic [S_WIDTH-1:0]   base_s, sum_s;
    logic                 sum_ovf_s;
    logic [ACC_WIDTH-1:0] res_s;

    // Pick the addend for the product: nothing, c, or the running accumulator
    always_comb begin
        base_s = {S_WIDTH{1'b0}};
        case (MODE)
            32'sd1: base_s = acc_ext(c_m_s);
            32'sd2: begin
                if (load_m_s) begin
                    base_s = acc_ext(c_m_s);
                end else if (clr_m_s) begin
                    base_s = {S_WIDTH{1'b0}};
                end else begin
                    base_s = acc_ext(acc_q);
                end
            end
            default: base_s = {S_WIDTH{1'b0}};
        endcase
    end

    // Exact sum at ACC_WIDTH+1 bits, overflow detect, then wrap or clamp
    always_comb begin
        sum_s     = base_s + prod_m_s;
        sum_ovf_s = ovf_of(sum_s);
        res_s     = fit(sum_s, sum_ovf_s);
    end

    // Next result, valid tag and sticky flag; MODE 2 only moves on valid beats
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = valid_m_s;
        case (MODE)
            32'sd1: begin
                acc_d = res_s;
                if (valid_m_s) begin
                    ovf_d = ovf_q | sum_ovf_s;
                end else begin
                    ovf_d = ovf_q;
                end
            end
            32'sd2: begin
                if (valid_m_s) begin
                    acc_d = res_s;
                    if (clr_m_s || load_m_s) begin
                        ovf_d = sum_ovf_s;
                    end else begin
                        ovf_d = ovf_q | sum_ovf_s;
                    end
                end else begin
                    acc_d = acc_q;
                    ovf_d = ovf_q;
                end
            end
            default: begin
                acc_d = res_s;
                ovf_d = 1'b0;
            end
        endcase
    end

    // Stage P: result/accumulator, output valid and sticky overflow
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q       <= {ACC_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (ce_i) begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // Without stage P the result and flag are presented in the beat's own cycle.
    assign y_o         = USE_P ? acc_q       : res_s;
    assign out_valid_o = USE_P ? out_valid_q : valid_m_s;
    assign ovf_o       = USE_P ? ovf_q       : ovf_d;

endmodule

// File: tb/tb_efpga_macc_param.sv
// Scoreboard bench for efpga_macc_param: six configurations share one stimulus
// stream; a value-level model predicts each result at issue time and a monitor
// pops and compares whenever a DUT presents a beat that its consumer takes (ce=1).
`timescale 1ns/1ps
module tb_efpga_macc_param;

    logic        clk = 1'b0;
    logic        rst, ce, in_valid, acc_clr, acc_load;
    logic [17:0] a, b;
    logic [39:0] c;
    logic [39:0] y0, y1;
    logic [35:0] y2, y3, y4, y5;
    logic [5:0]  ov_v, ovf_v;

    always #5 clk = ~clk;

    // configuration table, one entry per instance below
    int cfg_mode [6] = '{0, 2, 2, 2, 1, 1};
    bit cfg_sg   [6] = '{1, 1, 1, 1, 0, 1};
    int cfg_w    [6] = '{40, 40, 36, 36, 36, 36};
    bit cfg_sat  [6] = '{0, 0, 1, 0, 0, 1};
    int cfg_lat  [6] = '{3, 2, 2, 3, 3, 0};

    efpga_macc_param #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(40), .MODE(0), .SIGNED(1),
        .REG_IN(1), .PIPE_MULT(1), .REG_OUT(1), .SATURATE(0)) u0 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .c_i(c),
        .acc_clr_i(acc_clr), .acc_load_i(acc_load), .y_o(y0), .out_valid_o(ov_v[0]), .ovf_o(ovf_v[0]));
    efpga_macc_param #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(40), .MODE(2), .SIGNED(1),
        .REG_IN(1), .PIPE_MULT(0), .REG_OUT(1), .SATURATE(0)) u1 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .c_i(c),
        .acc_clr_i(acc_clr), .acc_load_i(acc_load), .y_o(y1), .out_valid_o(ov_v[1]), .ovf_o(ovf_v[1]));
    efpga_macc_param #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(36), .MODE(2), .SIGNED(1),
        .REG_IN(1), .PIPE_MULT(0), .REG_OUT(1), .SATURATE(1)) u2 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .c_i(c[35:0]),
        .acc_clr_i(acc_clr), .acc_load_i(acc_load), .y_o(y2), .out_valid_o(ov_v[2]), .ovf_o(ovf_v[2]));
    efpga_macc_param #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(36), .MODE(2), .SIGNED(1),
        .REG_IN(1), .PIPE_MULT(1), .REG_OUT(1), .SATURATE(0)) u3 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .c_i(c[35:0]),
        .acc_clr_i(acc_clr), .acc_load_i(acc_load), .y_o(y3), .out_valid_o(ov_v[3]), .ovf_o(ovf_v[3]));
    efpga_macc_param #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(36), .MODE(1), .SIGNED(0),
        .REG_IN(1), .PIPE_MULT(1), .REG_OUT(1), .SATURATE(0)) u4 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .c_i(c[35:0]),
        .acc_clr_i(acc_clr), .acc_load_i(acc_load), .y_o(y4), .out_valid_o(ov_v[4]), .ovf_o(ovf_v[4]));
    efpga_macc_param #(.A_WIDTH(18), .B_WIDTH(18), .ACC_WIDTH(36), .MODE(1), .SIGNED(1),
        .REG_IN(0), .PIPE_MULT(0), .REG_OUT(0), .SATURATE(1)) u5 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .in_valid_i(in_valid), .a_i(a), .b_i(b), .c_i(c[35:0]),
        .acc_clr_i(acc_clr), .acc_load_i(acc_load), .y_o(y5), .out_valid_o(ov_v[5]), .ovf_o(ovf_v[5]));

    typedef struct {
        longint y;
        bit     ovf;
        int     tag;
    } exp_t;

    exp_t   q_exp [6][$];
    longint m_acc [6];
    bit     m_ovf [6];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     en_cnt   = 0;
    bit     ce_rand  = 1'b0;
    logic [7:0] ce_pat = 8'd0;

    // number of enabled clock edges so far; a beat's latency is counted in these
    always @(posedge clk) if (ce) en_cnt <= en_cnt + 1;

    task automatic chk(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    // interpret the low w bits of raw as a signed or unsigned integer
    function automatic longint to_val(input logic [63:0] raw, input int w, input bit sgn);
        logic [63:0] m;
        longint v;
        m = raw & ((64'd1 << w) - 64'd1);
        v = longint'(m);
        if (sgn && m[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic longint get_y(input int k);
        logic [63:0] raw;
        case (k)
            0: raw = 64'(y0);
            1: raw = 64'(y1);
            2: raw = 64'(y2);
            3: raw = 64'(y3);
            4: raw = 64'(y4);
            default: raw = 64'(y5);
        endcase
        return to_val(raw, cfg_w[k], cfg_sg[k]);
    endfunction

    // Reference: integer arithmetic on the operand values, range check, clamp or wrap.
    function automatic void model(input int k, input logic [17:0] ta, input logic [17:0] tb,
                                  input logic [39:0] tc, input bit clr, input bit load,
                                  output longint y, output bit ov);
        longint av, bv, cv, p, s, lo, hi;
        int     w;
        bit     over;
        w  = cfg_w[k];
        av = to_val(64'(ta), 18, cfg_sg[k]);
        bv = to_val(64'(tb), 18, cfg_sg[k]);
        cv = to_val(64'(tc), w, cfg_sg[k]);
        p  = av * bv;
        if (cfg_sg[k]) begin
            hi = (longint'(1) << (w - 1)) - 1;
            lo = -(longint'(1) << (w - 1));
        end else begin
            hi = (longint'(1) << w) - 1;
            lo = 0;
        end
        if (cfg_mode[k] == 0) s = p;
        else if (cfg_mode[k] == 1) s = p + cv;
        else begin
            if (load) s = cv + p;
            else if (clr) s = p;
            else s = m_acc[k] + p;
            if (clr || load) m_ovf[k] = 1'b0;
        end
        over = (s > hi) || (s < lo);
        if (!over) y = s;
        else if (cfg_sat[k]) y = (s > hi) ? hi : lo;
        else y = to_val(64'(s), w, cfg_sg[k]);
        if (cfg_mode[k] == 2) m_acc[k] = y;
        if (cfg_mode[k] != 0 && over) m_ovf[k] = 1'b1;
        ov = (cfg_mode[k] == 0) ? 1'b0 : m_ovf[k];
    endfunction

    task automatic pick_ce();
        if (ce_pat != 8'd0) begin
            ce     = ~ce_pat[0];
            ce_pat = ce_pat >> 1;
        end else if (ce_rand) begin
            ce = ($urandom_range(0, 3) != 0);
        end else begin
            ce = 1'b1;
        end
    endtask

    // Present one beat and hold it until a cycle with ce=1 accepts it.
    task automatic send(input logic [17:0] ta, input logic [17:0] tb, input logic [39:0] tc,
                        input bit clr, input bit load);
        bit     done;
        longint ey;
        bit     eo;
        done = 1'b0;
        a = ta; b = tb; c = tc; acc_clr = clr; acc_load = load; in_valid = 1'b1;
        while (!done) begin
            pick_ce();
            if (ce) begin
                for (int k = 0; k < 6; k++) begin
                    model(k, ta, tb, tc, clr, load, ey, eo);
                    q_exp[k].push_back('{ey, eo, en_cnt});
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Invalid cycles with junk on the data and sideband pins.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            a = 18'($urandom); b = 18'($urandom); c = {8'($urandom), 32'($urandom)};
            acc_clr = 1'($urandom); acc_load = 1'($urandom);
            pick_ce();
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every beat a consumer takes is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && ce) begin
            for (int k = 0; k < 6; k++) begin
                if (ov_v[k]) begin
                    if (q_exp[k].size() == 0) begin
                        chk($sformatf("u%0d_unexpected_beat", k), 1, 0);
                    end else begin
                        exp_t e;
                        e = q_exp[k].pop_front();
                        chk($sformatf("u%0d_y", k), get_y(k), e.y);
                        chk($sformatf("u%0d_ovf", k), longint'(ovf_v[k]), longint'(e.ovf));
                        chk($sformatf("u%0d_latency", k), longint'(en_cnt - e.tag), longint'(cfg_lat[k]));
                    end
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_u%0d_y", tag, k), get_y(k), 0);
            chk($sformatf("%s_u%0d_out_valid", tag, k), longint'(ov_v[k]), 0);
            chk($sformatf("%s_u%0d_ovf", tag, k), longint'(ovf_v[k]), 0);
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; acc_load = 1'b0;
        a = 18'd0; b = 18'd0; c = 40'd0;
        for (int k = 0; k < 6; k++) begin m_acc[k] = 0; m_ovf[k] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        idle(2);

        // -3 * 7
        send(18'h3FFFD, 18'd7, 40'd0, 1'b0, 1'b0);
        // clear then accumulate: 6, 26, 16
        send(18'd2, 18'd3, 40'd0, 1'b1, 1'b0);
        send(18'd4, 18'd5, 40'd0, 1'b0, 1'b0);
        send(18'h3FFFF, 18'd10, 40'd0, 1'b0, 1'b0);
        idle(4);
        // load near the positive limit, then restart with a clear
        send(18'd4, 18'd4, 40'h07_FFFF_FFF6, 1'b0, 1'b1);
        send(18'd1, 18'd1, 40'd0, 1'b1, 1'b0);
        // unsigned carry-out, then a clean beat (flag must stay set)
        send(18'h3FFFF, 18'h3FFFF, 40'h0F_FFFF_FFFF, 1'b0, 1'b0);
        send(18'd1, 18'd1, 40'd0, 1'b0, 1'b0);
        idle(4);
        // stalls: ce low on the second and fifth cycle of the sequence
        ce_pat = 8'b0001_0010;
        send(18'd5, 18'd6, 40'd0, 1'b1, 1'b0);
        send(18'd7, 18'd8, 40'd0, 1'b0, 1'b0);
        send(18'd9, 18'd10, 40'd0, 1'b0, 1'b0);
        idle(6);
        // reset with beats still in the pipeline
        send(18'd10, 18'd10, 40'd0, 1'b1, 1'b0);
        idle(3);
        send(18'd1, 18'd1, 40'd0, 1'b0, 1'b0);
        send(18'd2, 18'd2, 40'd0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1 check_zero("midrst");
        for (int k = 0; k < 6; k++) begin q_exp[k].delete(); m_acc[k] = 0; m_ovf[k] = 1'b0; end
        @(posedge clk);
        #1 rst = 1'b0;
        send(18'd3, 18'd5, 40'd0, 1'b0, 1'b0);
        idle(5);

        // randomized traffic with random stalls and gaps
        ce_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [17:0] ra, rb;
            logic [39:0] rc;
            ra = 18'($urandom);
            rb = 18'($urandom);
            if ($urandom_range(0, 2) == 0) ra = 18'($urandom_range(0, 31)) - 18'd16;
            if ($urandom_range(0, 2) == 0) rb = 18'($urandom_range(0, 31)) - 18'd16;
            rc = {8'($urandom), 32'($urandom)};
            send(ra, rb, rc, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        // drain, bounded
        ce_rand = 1'b0;
        for (int t = 0; t < 50; t++) begin
            int pend;
            pend = 0;
            for (int k = 0; k < 6; k++) pend += q_exp[k].size();
            if (pend != 0) idle(1);
        end
        for (int k = 0; k < 6; k++) chk($sformatf("u%0d_drain_left", k), q_exp[k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/efpga_macc_param.md
Name: efpga_macc_param

Overview:
- Parametrised successor to the fixed efpga_mult/efpga_mult_addc/efpga_macc cell family.
- A single configurable multiply / multiply-add / multiply-accumulate datapath with:
  - generic operand and accumulator widths;
  - optional input and product pipeline registers;
  - signed/unsigned arithmetic;
  - saturation and a sticky overflow flag;
  - valid-tagged data with a clock enable.
- Used as the DSP techmap target when operand widths or register placement do not match a fixed cell.

Parameters:
- A_WIDTH, 18, operand a width (2..27)
- B_WIDTH, 18, operand b width (2..27)
- ACC_WIDTH, 40, result/accumulator/c width; must be >= A_WIDTH+B_WIDTH, elaboration error otherwise
- MODE, 0, 0=multiply, 1=multiply + c, 2=multiply-accumulate
- SIGNED, 1, 1=two's-complement operands/result, 0=unsigned
- REG_IN, 1, 1=register a, b, c and sideband at input (stage I)
- PIPE_MULT, 0, 1=register raw product (stage M)
- REG_OUT, 1, 1=register result (stage P); forced to 1 when MODE=2
- SATURATE, 0, 1=clamp on overflow, 0=wrap

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; 0 freezes every pipeline register, accumulator and flag
- in_valid  in  1  qualifies a, b, c, acc_clr, acc_load this cycle
- a  in  A_WIDTH  operand a
- b  in  B_WIDTH  operand b
- c  in  ACC_WIDTH  addend (MODE 1) / load value (MODE 2)
- acc_clr  in  1  MODE 2: this beat starts a new sum (acc = product); clears ovf
- acc_load  in  1  MODE 2: this beat sets acc = c + product; clears ovf
- y  out  ACC_WIDTH  result
- out_valid  out  1  y carries a valid beat
- ovf  out  1  sticky overflow (MODE 1 and 2); always 0 in MODE 0

Behaviour:
- Reset (async assert, sync release):
  - all stage registers, accumulator, y, out_valid and ovf = 0;
  - reset mid-stream discards in-flight beats.
- Latency L = REG_IN + PIPE_MULT + REG_OUT cycles from in_valid to out_valid.
  - L=0 only when MODE≠2 with all three registers off: fully combinational, out_valid = in_valid.
- ce gating:
  - with ce=0, no register updates, including sideband valids;
  - a beat is accepted only on a cycle with ce=1 and in_valid=1;
  - beats are never duplicated or dropped across ce low periods.
- Product:
  - prod = a*b at full A_WIDTH+B_WIDTH bits;
  - sign-extended (SIGNED=1) or zero-extended to ACC_WIDTH+1 for the add;
  - the product itself never overflows.
- MODE 0: y = extended prod. Stage registers still update on invalid beats, but out_valid tracks only valid beats.
- MODE 1:
  - c travels with a/b through stage I;
  - sum = prod + c computed at ACC_WIDTH+1 bits;
  - overflow when the result does not fit ACC_WIDTH (signed: sum[ACC_WIDTH]≠sum[ACC_WIDTH-1]; unsigned: carry out);
  - ovf sets on any overflowing valid beat and never self-clears, only rst.
- MODE 2:
  - the accumulator is the P register; it updates only on valid beats reaching stage P;
  - acc_clr: acc = prod.
  - acc_load: acc = c + prod.
  - neither: acc = acc + prod.
  - acc_clr and acc_load both 1: acc_load wins.
  - Either clear/load clears ovf, then ovf |= overflow of that same beat.
  - y = acc; out_valid pulses one cycle per accumulated beat.
- Saturation (SATURATE=1), on overflow:
  - signed: clamp to max positive or min negative by sign of the true sum;
  - unsigned: clamp to all-ones.
  - SATURATE=0 wraps modulo 2^ACC_WIDTH.
  - ovf is set identically in both cases.
- Sideband: acc_clr/acc_load are pipelined with their beat, so they take effect exactly when that beat's product arrives. Back-to-back clr beats with no gap are legal.
- Invalid beats never modify acc or ovf.

Test Plan:
- MODE0, SIGNED=1, REG_IN=1, PIPE_MULT=1, REG_OUT=1, a=-3, b=7 -> y=-21 (sign-extended 40 b), out_valid exactly 3 cycles after in_valid.
- MODE2, default widths: acc_clr with a=2,b=3, then a=4,b=5, then a=-1,b=10 on consecutive cycles -> y = 6, 26, 16 on three consecutive out_valid cycles; ovf=0.
- MODE2, ACC_WIDTH=36, A=B=18, SATURATE=1, SIGNED=1: acc_load c=2^35-10 with a=b=4 -> y=2^35-1, ovf=1; next beat acc_clr a=1,b=1 -> y=1, ovf=0. Repeat with SATURATE=0 -> first y wraps to -2^35+6.
- MODE1, SIGNED=0, ACC_WIDTH=36: a=b=2^18-1, c=2^36-1 -> overflow; SATURATE=0 gives y=(2^18-1)^2-1 mod 2^36, ovf=1 sticky through a following clean beat.
- ce toggling: valid beats on cycles 0,1,2 with ce low on cycles 1 and 4 -> all three results appear in order, none duplicated; accumulator sum matches the no-stall run.
- rst asserted mid-accumulation (2 beats in flight, acc=100) -> y, out_valid, ovf go 0 immediately; the next acc-less beat accumulates from 0.
